tcd1290d_timing_gen: RTL
========================

// Module: tcd1290d_timing_gen
// PURPOSE
//  Generates the CCD drive timing for the TCD1290D linear sensor: SH transfer gate, complementary
//  F1/F2 shift clocks, RS reset and CP clamp pulses. It is the source end of the SH/F2/RS interface.
//  The AD9945 ADC driver consumes that interface: it waits for SH to fall, then counts F2 rising edges.
//  Sits between the system control registers and the sensor/ADC; runs on the same sys_clk as the ADC driver.
// PARAMETERS
//  HALF_PER   10    sys_clk cycles per F1/F2 half period; pixel period P = 2*HALF_PER (>=4)
//  PIX_NUM    2100  pixel periods per readout. Must be >= ADC driver sample count + 1
//  SH_SETUP   50    cycles with F1=1/F2=0 before SH rises (t1)
//  SH_WIDTH   100   SH high cycles
//  SH_HOLD    50    cycles after SH falls, before the first F2 rise (t3)
//  RS_OFFSET  2     phase cycles after the F2 rise at which RS rises
//  RS_WIDTH   3     RS high cycles
//  CP_WIDTH   3     CP high cycles, starting immediately after RS falls
//                   Legal only if RS_OFFSET+RS_WIDTH+CP_WIDTH <= HALF_PER
// PORTS
//  sys_clk     in   1   system clock, 100 MHz
//  rst         in   1   asynchronous active-high reset
//  enable      in   1   1 = run lines continuously; 0 = stop after the current line
//  int_ext     in   16  extra integration, in pixel periods, appended after readout; sampled at SH rise
//  sh          out  1   transfer gate pulse
//  f1          out  1   shift clock phase 1
//  f2          out  1   shift clock phase 2
//  rs          out  1   output reset pulse
//  cp          out  1   clamp pulse
//  line_start  out  1   1-cycle pulse, coincident with SH rising
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - One clock, sys_clk. rst is asynchronous and active-high; all outputs are registered.
//  - Reset values: sh=f1=f2=rs=cp=line_start=busy=0. State=IDLE, all counters 0.
//  - States: IDLE -> SETUP -> SHPULSE -> HOLD -> READOUT -> (INTEG) -> SETUP... or -> IDLE.
//  - IDLE: all outputs 0. Enter SETUP on the first clock with enable=1.
//  - SETUP: f1=1, f2=0, rs=cp=0. Lasts SH_SETUP cycles.
//  - SHPULSE: sh=1, f1=1, f2=0 for SH_WIDTH cycles.
//    - line_start=1 on the first of these cycles.
//    - int_ext is latched into a 16-bit register on that cycle.
//  - HOLD: sh=0, f1=1, f2=0 for SH_HOLD cycles.
//  - READOUT: phase counter ph runs 0..P-1 and wraps; pixel counter counts wraps.
//    - f2 = (ph < HALF_PER); f1 = ~f2.
//    - rs = (RS_OFFSET <= ph < RS_OFFSET+RS_WIDTH).
//    - cp = (RS_OFFSET+RS_WIDTH <= ph < RS_OFFSET+RS_WIDTH+CP_WIDTH).
//    - Exactly PIX_NUM F2 rising edges occur, spaced exactly P cycles apart.
//    - The first F2 rise lands SH_HOLD cycles after SH falls.
//  - INTEG: identical clocking to READOUT for int_ext pixel periods. Skipped when the latched int_ext=0.
//  - End of line (after the last period of READOUT/INTEG): enable=1 -> SETUP; enable=0 -> IDLE.
//    - f2 is 0 and f1 is 1 at the transition.
//  - Line period = SH_SETUP + SH_WIDTH + SH_HOLD + (PIX_NUM + int_ext) * P cycles, with no dead cycles.
//  - enable falling mid-line never truncates the line. Changes to int_ext mid-line are ignored.
//  - Invariants in every cycle:
//    - f1 & f2 == 0 outside IDLE.
//    - sh=1 implies f1=1 and rs=cp=0.
//    - rs & cp == 0.
//  - Counters are sized from the parameters (clog2). The pixel counter is 17 bits so it covers PIX_NUM + 65535.
// TESTING (bench parameters: HALF_PER=4 PIX_NUM=8 SH_SETUP=5 SH_WIDTH=6 SH_HOLD=3 RS_OFFSET=1 RS_WIDTH=1 CP_WIDTH=1)
//  1 rst=1, then release with enable=0 for 50 cycles -> all outputs stay 0, busy=0.
//  2 enable=1, int_ext=0 -> sh high for 6 cycles; first F2 rise 3 cycles after SH falls.
//    -> 8 F2 rises, 8 cycles apart; line_start pulses every 78 cycles.
//  3 int_ext=2 -> 10 F2 rises per line, line period 94. Changing int_ext mid-line takes effect on the next line only.
//  4 Drop enable during pixel 3 -> line completes all 8 pixels; next cycle IDLE, busy=0, no further sh.
//  5 Assert rst mid-SHPULSE -> all outputs 0 without waiting for a clock edge.
//    -> after release with enable=1, SETUP begins cleanly.
//  6 Every pixel: rs high at ph=1, cp high at ph=2. Assert continuously that f1&f2, sh&rs and rs&cp never occur.

Source files
------------

// File: rtl/tcd1290d_timing_gen.sv
// -----------------------------------------------------------------------------
// tcd1290d_timing_gen
//   CCD drive timing for the TCD1290D linear sensor. Produces the SH transfer
//   gate, complementary F1/F2 shift clocks, the RS output-reset pulse and the
//   CP clamp pulse. The downstream ADC driver waits for SH to fall and then
//   counts F2 rising edges, so F2 edge placement is exact and gap-free.
//
// Ports
//   sys_clk    in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   enable     in   1   1 = run lines back to back, 0 = stop after current line
//   int_ext    in  16   extra integration (pixel periods), latched at SH rise
//   sh         out  1   transfer gate pulse
//   f1, f2     out  1   shift clock phases (never both high)
//   rs         out  1   output reset pulse
//   cp         out  1   clamp pulse, immediately after rs
//   line_start out  1   one-cycle pulse on the first SH-high cycle
//   busy       out  1   high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module tcd1290d_timing_gen #(
  parameter int HALF_PER  = 10,
  parameter int PIX_NUM   = 2100,
  parameter int SH_SETUP  = 50,
  parameter int SH_WIDTH  = 100,
  parameter int SH_HOLD   = 50,
  parameter int RS_OFFSET = 2,
  parameter int RS_WIDTH  = 3,
  parameter int CP_WIDTH  = 3
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] int_ext,
  output logic        sh,
  output logic        f1,
  output logic        f2,
  output logic        rs,
  output logic        cp,
  output logic        line_start,
  output logic        busy
);

  localparam int P       = 2 * HALF_PER;
  localparam int PH_W    = $clog2(P);
  localparam int CNT_MAX = (SH_SETUP > SH_WIDTH) ?
                           ((SH_SETUP > SH_HOLD) ? SH_SETUP : SH_HOLD) :
                           ((SH_WIDTH > SH_HOLD) ? SH_WIDTH : SH_HOLD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SH_SETUP - 1);
  localparam logic [CNT_W-1:0] SHW_LAST   = CNT_W'(SH_WIDTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SH_HOLD - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(P - 1);
  localparam logic [PH_W-1:0]  HALF_PH    = PH_W'(HALF_PER);
  localparam logic [PH_W-1:0]  RS_BEG     = PH_W'(RS_OFFSET);
  localparam logic [PH_W-1:0]  RS_END     = PH_W'(RS_OFFSET + RS_WIDTH);
  localparam logic [PH_W-1:0]  CP_END     = PH_W'(RS_OFFSET + RS_WIDTH + CP_WIDTH);
  localparam logic [16:0]      PIX_LAST   = 17'(PIX_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHPULSE,
    S_HOLD,
    S_READOUT,
    S_INTEG
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_next;
  logic [PH_W-1:0]   r_ph,    w_ph_next;
  logic [16:0]       r_pix,   w_pix_next;
  logic [15:0]       r_int_lat, w_int_next;

  logic r_sh, r_f1, r_f2, r_rs, r_cp, r_ls, r_busy;
  logic w_sh_next, w_f1_next, w_f2_next, w_rs_next, w_cp_next, w_ls_next, w_busy_next;
  logic w_scan;

  // The pixel counter runs straight through READOUT into INTEG, so the last
  // pixel of INTEG is PIX_NUM + int_ext - 1.
  logic [16:0] w_integ_last;
  logic        w_line_done;

  assign w_integ_last = PIX_LAST + {1'b0, r_int_lat};
  assign w_line_done  = (r_state == S_READOUT) ?
                        ((r_pix == PIX_LAST) && (r_int_lat == 16'd0)) :
                        (r_pix == w_integ_last);

  // Next-state and counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ph_next    = r_ph;
    w_pix_next   = r_pix;
    w_int_next   = r_int_lat;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_SETUP;
          w_cnt_next   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_next = S_SHPULSE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_SHPULSE: begin
        // Integration extension is frozen on the first SH-high cycle so that
        // mid-line writes only affect the following line.
        if (r_cnt == '0) begin
          w_int_next = int_ext;
        end
        if (r_cnt == SHW_LAST) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_next = S_READOUT;
          w_cnt_next   = '0;
          w_ph_next    = '0;
          w_pix_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_READOUT, S_INTEG: begin
        if (r_ph == PH_LAST) begin
          w_ph_next = '0;
          if (w_line_done) begin
            // Line boundary: enable is only looked at here, never mid-line.
            w_pix_next   = '0;
            w_cnt_next   = '0;
            w_state_next = enable ? S_SETUP : S_IDLE;
          end else begin
            w_pix_next = r_pix + 17'd1;
            if ((r_state == S_READOUT) && (r_pix == PIX_LAST)) begin
              w_state_next = S_INTEG;
            end
          end
        end else begin
          w_ph_next = r_ph + PH_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_ph_next    = '0;
        w_pix_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state/phase and registered, so each
  // output register reflects the state register in the same cycle.
  always_comb begin
    w_scan      = (w_state_next == S_READOUT) || (w_state_next == S_INTEG);
    w_sh_next   = (w_state_next == S_SHPULSE);
    w_f2_next   = w_scan && (w_ph_next < HALF_PH);
    w_f1_next   = (w_state_next != S_IDLE) && !w_f2_next;
    w_rs_next   = w_scan && (w_ph_next >= RS_BEG) && (w_ph_next < RS_END);
    w_cp_next   = w_scan && (w_ph_next >= RS_END) && (w_ph_next < CP_END);
    w_ls_next   = (w_state_next == S_SHPULSE) && (r_state != S_SHPULSE);
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ph      <= '0;
      r_pix     <= '0;
      r_int_lat <= '0;
      r_sh      <= 1'b0;
      r_f1      <= 1'b0;
      r_f2      <= 1'b0;
      r_rs      <= 1'b0;
      r_cp      <= 1'b0;
      r_ls      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ph      <= w_ph_next;
      r_pix     <= w_pix_next;
      r_int_lat <= w_int_next;
      r_sh      <= w_sh_next;
      r_f1      <= w_f1_next;
      r_f2      <= w_f2_next;
      r_rs      <= w_rs_next;
      r_cp      <= w_cp_next;
      r_ls      <= w_ls_next;
      r_busy    <= w_busy_next;
    end
  end

  assign sh         = r_sh;
  assign f1         = r_f1;
  assign f2         = r_f2;
  assign rs         = r_rs;
  assign cp         = r_cp;
  assign line_start = r_ls;
  assign busy       = r_busy;

endmodule
